// File: rtl/npc_pkg.sv
// Shared definitions for the npc core fetch path: next-PC select codes,
// reset vector and the PC sequencer state encoding.
package npc_pkg;

  typedef logic [1:0] pc_src_t;

  localparam pc_src_t PC_SRC_SEQ  = 2'b00;
  localparam pc_src_t PC_SRC_JAL  = 2'b01;
  localparam pc_src_t PC_SRC_JALR = 2'b10;
  localparam pc_src_t PC_SRC_RSV  = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Sequencer states; plain constants so older tools and dumps decode them.
  localparam logic [2:0] ST_BOOT  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection. Adds wrap modulo 2^XLEN; the jalr target
// has bit 0 cleared before the alignment test, so only bit 1 can flag it.
module pc_next_calc
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        [XLEN-1:0] pc,
  input  logic        [1:0]      pc_src,
  input  logic signed [XLEN-1:0] imm,
  input  logic        [XLEN-1:0] rs1_data,
  output logic        [XLEN-1:0] next_pc,
  output logic                   misaligned
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] jal_pc;
  logic [XLEN-1:0] jalr_pc;

  // Form all candidate targets, then pick one by pc_src.
  always_comb begin
    seq_pc  = pc + XLEN'(4);
    jal_pc  = pc + imm;
    jalr_pc = (rs1_data + imm) & ~XLEN'(1);
    next_pc = seq_pc;
    case (pc_src)
      PC_SRC_SEQ:  next_pc = seq_pc;
      PC_SRC_JAL:  next_pc = jal_pc;
      PC_SRC_JALR: next_pc = jalr_pc;
      PC_SRC_RSV:  next_pc = seq_pc;
      default:     next_pc = seq_pc;
    endcase
    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/pc_seq.sv
// Multi-cycle fetch/PC sequencer: owns the architectural PC, fetches one
// instruction at a time over a valid/ready request and holds it until the
// execute stage reports the next-PC select. All outputs decode registered state.
module pc_seq
  import npc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            exec_valid,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            halt,
  output logic            halted,
  output logic            misalign
);

  logic [2:0]      state;
  logic [XLEN-1:0] pc;
  logic [31:0]     inst_q;
  logic            misalign_q;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  pc_next_calc #(
    .XLEN(XLEN)
  ) u_next (
    .pc        (pc),
    .pc_src    (pc_src),
    .imm       (imm),
    .rs1_data  (rs1_data),
    .next_pc   (next_pc),
    .misaligned(next_misaligned)
  );

  // Sequencer FSM with PC, held instruction and sticky misalign flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      inst_q     <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_req_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            inst_q <= imem_rsp_data;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (exec_valid) begin
            if (halt) begin
              state <= ST_HALT;
            end else if (next_misaligned) begin
              misalign_q <= 1'b1;
              state      <= ST_HALT;
            end else begin
              pc    <= next_pc;
              state <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

  assign imem_req_valid = (state == ST_FETCH);
  assign inst_valid     = (state == ST_ISSUE);
  assign halted         = (state == ST_HALT);
  assign imem_req_addr  = pc;
  assign inst_pc        = pc;
  assign inst           = inst_q;
  assign misalign       = misalign_q;

endmodule

// File: tb/tb_pc_seq.sv
module tb_pc_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        exec_valid;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        halt;
  logic        halted;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  pc_seq dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .exec_valid    (exec_valid),
    .pc_src        (pc_src),
    .imm           (imm),
    .rs1_data      (rs1_data),
    .halt          (halt),
    .halted        (halted),
    .misalign      (misalign)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Architectural next-PC rule.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] src,
                                           input logic [31:0] im, input logic [31:0] r1);
    case (src)
      2'b01:   return pc + im;
      2'b10:   return (r1 + im) & 32'hFFFF_FFFE;
      default: return pc + 32'd4;
    endcase
  endfunction

  // Monitor: samples at negedge, pops expectations on handshakes / issue.
  initial begin
    logic        prev_wait;
    logic        prev_iv;
    logic [31:0] held_addr;
    logic [31:0] ea;
    logic [63:0] ei;
    prev_wait = 1'b0;
    prev_iv   = 1'b0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wait = 1'b0;
        prev_iv   = 1'b0;
      end else begin
        if (prev_wait) begin
          chk("req_valid_held", imem_req_valid, 1);
          chk("req_addr_stable", imem_req_addr, held_addr);
        end
        if ((32'(imem_req_valid) + 32'(inst_valid) + 32'(halted)) > 1)
          fail_now("outputs_exclusive");
        if (imem_req_valid && imem_req_ready) begin
          if (exp_addr_q.size() == 0) fail_now("unexpected_fetch");
          else begin
            ea = exp_addr_q.pop_front();
            chk("fetch_addr", imem_req_addr, ea);
          end
        end
        if (inst_valid && !prev_iv) begin
          if (exp_inst_q.size() == 0) fail_now("unexpected_issue");
          else begin
            ei = exp_inst_q.pop_front();
            chk("issue_inst_pc", {inst, inst_pc}, ei);
          end
        end
        prev_wait = imem_req_valid && !imem_req_ready;
        prev_iv   = inst_valid;
        held_addr = imem_req_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid, 0);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_misalign"}, misalign, 0);
    chk({tag, "_addr"}, imem_req_addr, RST_PC);
    chk({tag, "_inst_pc"}, inst_pc, RST_PC);
    chk({tag, "_inst"}, inst, 0);
  endtask

  // Hold reset for two edges, release, and check the BOOT quiet cycle.
  task automatic finish_reset();
    exp_addr_q.delete();
    exp_inst_q.delete();
    imem_req_ready = 0; imem_rsp_valid = 0; exec_valid = 0; halt = 0;
    tick();
    tick();
    check_reset_vals("in_reset");
    rst = 0;
    model_pc = RST_PC;
    #3;
    chk("boot_quiet", imem_req_valid, 0);
    @(posedge clk);
    #1;
    chk("boot_to_fetch", imem_req_valid, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    finish_reset();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 10) begin
      tick();
      n++;
    end
    chk("req_wait_bound", imem_req_valid, 1);
  endtask

  // Act as IMEM: stall, then accept, then respond after lat cycles (lat >= 1).
  task automatic do_fetch(input logic [31:0] data, input int stall, input int lat);
    exp_addr_q.push_back(model_pc);
    exp_inst_q.push_back({data, model_pc});
    wait_req();
    for (int i = 0; i < stall; i++) begin
      imem_req_ready = 0;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      tick();
    end
    imem_rsp_valid = 0;
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    for (int i = 1; i < lat; i++) begin
      exec_valid = 1'($urandom_range(0, 1));
      halt       = 1'($urandom_range(0, 1));
      pc_src     = 2'($urandom_range(0, 3));
      tick();
    end
    exec_valid = 0;
    halt = 0;
    imem_rsp_valid = 1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 0;
  endtask

  // Act as execute: report next-PC select; returns 1 when the core stopped.
  task automatic do_exec(input logic [1:0] src, input logic [31:0] im, input logic [31:0] r1,
                         input logic hlt, input int idle, output bit stopped);
    logic [31:0] nxt;
    bit          mis;
    for (int i = 0; i < idle; i++) begin
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      halt           = 1'($urandom_range(0, 1));
      tick();
    end
    imem_rsp_valid = 0;
    chk("inst_valid_before_exec", inst_valid, 1);
    exec_valid = 1; pc_src = src; imm = im; rs1_data = r1; halt = hlt;
    tick();
    exec_valid = 0; halt = 0; pc_src = 0;
    nxt = ref_next(model_pc, src, im, r1);
    mis = (nxt % 4) != 0;
    stopped = hlt || mis;
    if (stopped) begin
      for (int i = 0; i < 4; i++) begin
        chk("halted", halted, 1);
        chk("halt_no_req", imem_req_valid, 0);
        chk("halt_no_inst", inst_valid, 0);
        tick();
      end
      chk("misalign_flag", misalign, (!hlt && mis) ? 1 : 0);
      chk("halt_pc_kept", imem_req_addr, model_pc);
    end else begin
      model_pc = nxt;
    end
  endtask

  initial begin
    bit          st;
    logic [1:0]  rs;
    logic [31:0] ri, rr;
    rst = 1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    exec_valid = 0; pc_src = 0; imm = 0; rs1_data = 0; halt = 0;
    model_pc = RST_PC;
    #1;
    finish_reset();

    // Basic sequential instruction, zero-wait IMEM.
    do_fetch(32'h0000_0013, 0, 1);
    do_exec(2'b00, 0, 0, 0, 0, st);
    // Backpressure for three cycles.
    do_fetch(32'h1111_1111, 3, 2);
    do_exec(2'b00, 0, 0, 0, 1, st);
    do_fetch(32'h2222_2222, 0, 3);
    do_exec(2'b01, 32'd8, 0, 0, 0, st);          // -> 8000_0010
    do_fetch(32'h3333_3333, 1, 1);
    do_exec(2'b01, 32'hFFFF_FFF0, 0, 0, 2, st);  // -> 8000_0000
    do_fetch(32'h4444_4444, 0, 1);
    do_exec(2'b10, 32'd4, 32'h8000_0101, 0, 0, st); // -> 8000_0104
    do_fetch(32'h5555_5555, 0, 1);
    do_exec(2'b11, 32'd64, 0, 0, 0, st);         // reserved -> 8000_0108
    // Misaligned jal target.
    do_fetch(32'h6666_6666, 0, 1);
    do_exec(2'b01, 32'd2, 0, 0, 0, st);
    do_reset();
    // ebreak halt.
    do_fetch(32'h0010_0073, 0, 1);
    do_exec(2'b01, 32'h40, 0, 1, 0, st);
    do_reset();
    // Wrap-around at top of address space.
    do_fetch(32'h7777_7777, 0, 1);
    do_exec(2'b10, 32'd4, 32'hFFFF_FFF8, 0, 0, st); // -> FFFF_FFFC
    do_fetch(32'h8888_8888, 0, 1);
    do_exec(2'b00, 0, 0, 0, 0, st);              // -> 0000_0000
    do_fetch(32'h9999_9999, 0, 1);
    do_exec(2'b00, 0, 0, 0, 0, st);              // -> 0000_0004
    // Asynchronous reset while a request is outstanding.
    exp_addr_q.push_back(model_pc);
    wait_req();
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    #3;
    rst = 1;
    #1;
    check_reset_vals("async_rst");
    finish_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      do_fetch($urandom, $urandom_range(0, 3), $urandom_range(1, 4));
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ri = 32'($urandom_range(0, 15)) - 32'd8;
      else ri = (32'($urandom_range(0, 255)) - 32'd128) * 32'd4;
      rr = model_pc + 32'd4 * 32'($urandom_range(0, 8));
      if ($urandom_range(0, 4) == 0) rr = rr + 32'($urandom_range(1, 3));
      do_exec(rs, ri, rr, 1'($urandom_range(0, 29) == 0), $urandom_range(0, 2), st);
      if (st) do_reset();
    end

    tick();
    chk("addr_queue_drained", 64'(exp_addr_q.size()), 0);
    chk("inst_queue_drained", 64'(exp_inst_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
